mul32_seq_ctrl: RTL and testbench
=================================

// Module: mul32_seq_ctrl
// PURPOSE
//  Sequential shift-and-add controller for the 32x32 unsigned multiplier.
//  - Drives the external combinational 32->64 left-shift stage through sh_val/sh_amt.
//  - Accumulates the returned sh_res once per multiplier bit.
//  - start/ready/done handshake; a single unit of state serves one operation at a time.
// PARAMETERS
//  WIDTH  32               operand width; product and accumulator are 2*WIDTH
//  CW     $clog2(WIDTH)=5  bit-counter width; equals the shifter's shift-amount width
// PORTS
//  clk      in   1        clock, rising edge
//  rst      in   1        synchronous, active-high reset
//  start    in   1        request; accepted only when ready=1
//  a        in   WIDTH    multiplicand, sampled on the accepting edge
//  b        in   WIDTH    multiplier, sampled on the accepting edge
//  ready    out  1        1 in IDLE (combinational from state)
//  busy     out  1        1 in RUN
//  done     out  1        one-cycle pulse, 1 in DONE
//  product  out  2*WIDTH  registered result; holds until next completion
//  sh_val   out  WIDTH    shifter data input = latched a_q
//  sh_amt   out  CW       shifter shift amount = bit counter cnt
//  sh_res   in   2*WIDTH  shifter output, zero-extended sh_val<<sh_amt, same cycle
// BEHAVIOUR
//  - Reset values: state=IDLE, a_q=0, b_q=0, acc=0, cnt=0, product=0.
//    Resulting outputs: ready=1, busy=0, done=0, sh_val=0, sh_amt=0.
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, start=1: a_q<=a, b_q<=b, acc<=0, cnt<=0, go RUN. start=0: stay in IDLE.
//  - RUN, every cycle:
//    - if b_q[0]: acc<=acc+sh_res.
//    - b_q<=b_q>>1; cnt<=cnt+1.
//    - on the cycle cnt==WIDTH-1: product<=final acc (including this cycle's term), go DONE.
//    - cnt never wraps; RUN always exits at 31.
//  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//  - Latency (macro off): accept edge E0; RUN accumulates at E1..E32; done=1 in the cycle
//    after E32; ready=1 again after E33.
//  - Arithmetic is unsigned only. acc is 64 bits; max a*b < 2^64, so no overflow and no carry out.
//  - start while busy or in DONE is ignored: no queueing, no error.
//  - a/b changes after acceptance have no effect.
//  - start held high: a new operation is accepted on the first IDLE cycle after DONE.
//  - rst at any time, including mid-RUN or in DONE: next cycle is in reset state;
//    product cleared to 0; done never pulses for the aborted operation.
//  - sh_val/sh_amt are driven from registers in every state. The shifter path is
//    combinational into the acc adder, so it must meet single-cycle timing.
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined:
//    - RUN also exits to DONE on the cycle where (b_q>>1)==0 after the current step;
//      product<=final acc as above.
//    - RUN length = index of b's MSB set + 1, minimum 1 (b=0 -> 1 RUN cycle).
//  MUL_EARLY_EXIT_EN undefined:
//    - RUN is always exactly WIDTH cycles; latency is data-independent.
//  Results are identical in both builds.
// TESTING
//  1. a=3, b=5 -> product=0x0F.
//     done 33 cycles after the accept edge (macro off); 4 cycles (3 RUN) macro on.
//  2. a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; sh_amt steps 0..31 in RUN.
//  3. a=0x12345678, b=0 -> product=0.
//     Macro on: done 2 cycles after accept. Macro off: 33 cycles.
//  4. Accept a=7, b=9; pulse start with a=2, b=2 at RUN cycle 5 -> product=63;
//     the second request is ignored and busy stays continuous.
//  5. Accept a=10, b=10; rst=1 at RUN cycle 10 for one cycle -> next cycle ready=1,
//     busy=0, product=0; no done pulse.
//  6. start held high, a=4, b=6 then a=5, b=5 -> done pulses with product 24 then 25;
//     the second accept lands on the IDLE cycle right after the first DONE.

Source files
------------

// File: rtl/mul32_seq_ctrl.sv
// Sequential shift-and-add controller for a WIDTH x WIDTH unsigned multiplier using an external shifter.
// Optional MUL_EARLY_EXIT_EN: leave RUN once the remaining multiplier bits are all zero.
module mul32_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   sh_val,
    output logic [CW-1:0]      sh_amt,
    input  logic [2*WIDTH-1:0] sh_res
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] acc_sum;
    logic               last_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        acc_sum   = acc_q + (b_q[0] ? sh_res : '0);
        last_step = (cnt_q == CW'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
        last_step = last_step || ((b_q >> 1) == '0);
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum;
                b_d   = b_q >> 1;
                // Counter holds on the final step so it never wraps past WIDTH-1.
                if (last_step) begin
                    product_d = acc_sum;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready   = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;
    assign sh_val  = a_q;
    assign sh_amt  = cnt_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Self-checking bench for mul32_seq_ctrl: models the external shifter and compares against a*b.
module tb_mul32_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int CW    = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a_i, b_i;
    logic               ready, busy, done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   sh_val;
    logic [CW-1:0]      sh_amt;
    logic [2*WIDTH-1:0] sh_res;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb sh_res = 64'(sh_val) << sh_amt;

    mul32_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product),
        .sh_val  (sh_val),
        .sh_amt  (sh_amt),
        .sh_res  (sh_res)
    );

    // RUN cycles for multiplier b: edges from accept until done is observed.
    function automatic int ref_len(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int n;
        n = 1;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) n = i + 1;
        return n;
`else
        return WIDTH;
`endif
    endfunction

    function automatic logic [63:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Issue one operation from IDLE; returns result, edges to done and RUN-sequence sanity.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [63:0] prod, output int edges,
                         output bit seq_ok, output bit timed_out);
        start = 1'b1; a_i = a; b_i = b;
        @(posedge clk); #1;
        start = 1'b0; a_i = $urandom; b_i = $urandom;
        edges = 0; seq_ok = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            if (busy !== 1'b1 || ready !== 1'b0 || sh_amt !== 5'(edges) || sh_val !== a)
                seq_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        timed_out = (done !== 1'b1);
        prod = product;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++; $display("FAIL reset_flags got %b exp 100", {ready, busy, done});
        end
        n_cmp++;
        if (product !== 64'd0 || sh_val !== 32'd0 || sh_amt !== 5'd0) begin
            n_err++; $display("FAIL reset_data got prod=%h val=%h amt=%0d exp 0", product, sh_val, sh_amt);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] av[3] = '{32'd3, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [WIDTH-1:0] bv[3] = '{32'd5, 32'hFFFF_FFFF, 32'd0};
        logic [63:0]      ev[3] = '{64'h0F, 64'hFFFF_FFFE_0000_0001, 64'd0};
        logic [63:0] p; int e; bit ok, to;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], p, e, ok, to);
            n_cmp++;
            if (to || p !== ev[i]) begin
                n_err++; $display("FAIL directed%0d_product got %h exp %h timeout=%0d", i, p, ev[i], to);
            end
            n_cmp++;
            if (e != ref_len(bv[i])) begin
                n_err++; $display("FAIL directed%0d_latency got %0d exp %0d", i, e, ref_len(bv[i]));
            end
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL directed%0d_run_seq got bad exp busy/sh_amt stepping", i);
            end
            n_cmp++;
            if (ready !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL directed%0d_idle got ready=%b done=%b exp 1 0", i, ready, done);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b; logic [63:0] p; int e; bit ok, to;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            do_op(a, b, p, e, ok, to);
            n_cmp++;
            if (to || p !== ref_mul(a, b) || e != ref_len(b) || !ok) begin
                n_err++;
                $display("FAIL random%0d got prod=%h len=%0d seq=%0d exp prod=%h len=%0d (a=%h b=%h)",
                         i, p, e, ok, ref_mul(a, b), ref_len(b), a, b);
            end
        end
    endtask

    task automatic test_ignore_start();
        int pulse_at, e; bit cont;
        pulse_at = (ref_len(32'd9) - 1 < 5) ? ref_len(32'd9) - 1 : 5;
        start = 1'b1; a_i = 32'd7; b_i = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        e = 0; cont = 1'b1;
        while (done !== 1'b1 && e < 40) begin
            if (busy !== 1'b1) cont = 1'b0;
            if (e == pulse_at) begin start = 1'b1; a_i = 32'd2; b_i = 32'd2; end
            else start = 1'b0;
            @(posedge clk); #1;
            e++;
        end
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || product !== 64'd63) begin
            n_err++; $display("FAIL ignore_product got %0d done=%b exp 63", product, done);
        end
        n_cmp++;
        if (!cont || e != ref_len(32'd9)) begin
            n_err++; $display("FAIL ignore_busy got cont=%0d len=%0d exp 1 %0d", cont, e, ref_len(32'd9));
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b1 || product !== 64'd63) begin
            n_err++; $display("FAIL ignore_no_second got ready=%b prod=%0d exp 1 63", ready, product);
        end
    endtask

    task automatic test_reset_mid();
        int at; bit saw_done;
        at = (ref_len(32'd10) - 1 < 10) ? ref_len(32'd10) - 1 : 10;
        start = 1'b1; a_i = 32'd10; b_i = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (at) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre got busy=%b exp 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            n_err++; $display("FAIL rstmid_state got r=%b b=%b d=%b prod=%h exp 1 0 0 0",
                              ready, busy, done, product);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_err++; $display("FAIL rstmid_no_done got activity=1 exp 0");
        end
    endtask

    task automatic test_start_held();
        int e;
        start = 1'b1; a_i = 32'd4; b_i = 32'd6;
        @(posedge clk); #1;
        a_i = 32'd5; b_i = 32'd5;
        e = 0;
        while (done !== 1'b1 && e < 40) begin @(posedge clk); #1; e++; end
        n_cmp++;
        if (done !== 1'b1 || product !== 64'd24 || e != ref_len(32'd6)) begin
            n_err++; $display("FAIL held_first got prod=%0d len=%0d exp 24 %0d", product, e, ref_len(32'd6));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL held_idle got ready=%b exp 1", ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || sh_val !== 32'd5) begin
            n_err++; $display("FAIL held_accept got busy=%b sh_val=%0d exp 1 5", busy, sh_val);
        end
        e = 0;
        while (done !== 1'b1 && e < 40) begin @(posedge clk); #1; e++; end
        n_cmp++;
        if (done !== 1'b1 || product !== 64'd25 || e != ref_len(32'd5)) begin
            n_err++; $display("FAIL held_second got prod=%0d len=%0d exp 25 %0d", product, e, ref_len(32'd5));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
